// File: rtl/rv_pkg.sv
// Shared register-file writeback types for the pipeline and the long-latency unit.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic                  en;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // Writes to x0 are architectural no-ops and never occupy the port.
  function automatic logic wb_live(input wb_req_t r);
    return r.en && (r.addr != '0);
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Signal bundle between the writeback requesters, the long-latency unit and the
// register-file write port. The arbiter sits on the slave modport.
interface wb_port_arbiter_if #(
  parameter int DEPTH = 4
) ();
  import rv_pkg::*;

  // Long-latency handshake: an entry transfers on a rising edge where
  // i_lu_valid & o_lu_ready are both 1; o_lu_ready depends only on current
  // occupancy, and the producer holds addr/data stable until that transfer.
  logic                       i_register_file_wr_en_W;
  logic [REG_ADDR_W-1:0]      i_register_file_wr_addr_W;
  logic [XLEN-1:0]            i_result_W;
  logic                       i_lu_valid;
  logic [REG_ADDR_W-1:0]      i_lu_addr;
  logic [XLEN-1:0]            i_lu_data;
  logic                       o_lu_ready;
  logic                       o_rf_wr_en;
  logic [REG_ADDR_W-1:0]      o_rf_wr_addr;
  logic [XLEN-1:0]            o_rf_wr_data;
  logic                       o_starve;
  logic [$clog2(DEPTH+1)-1:0] o_count;

  modport slave (
    input  i_register_file_wr_en_W, i_register_file_wr_addr_W, i_result_W,
    input  i_lu_valid, i_lu_addr, i_lu_data,
    output o_lu_ready, o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_starve, o_count
  );

  modport master (
    output i_register_file_wr_en_W, i_register_file_wr_addr_W, i_result_W,
    output i_lu_valid, i_lu_addr, i_lu_data,
    input  o_lu_ready, o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_starve, o_count
  );

endinterface

// File: rtl/wb_lu_fifo.sv
// Long-latency result FIFO: each entry is {kill, addr, data}; live pipeline
// writes kill every queued entry with a matching destination.
module wb_lu_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [REG_ADDR_W-1:0]      push_addr_i,
  input  logic [XLEN-1:0]            push_data_i,
  input  logic                       pop_i,
  input  logic                       kill_en_i,
  input  logic [REG_ADDR_W-1:0]      kill_addr_i,
  output logic                       ready_o,
  output logic                       head_valid_o,
  output logic                       head_kill_o,
  output logic [REG_ADDR_W-1:0]      head_addr_o,
  output logic [XLEN-1:0]            head_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [REG_ADDR_W-1:0] addr_q [DEPTH];
  logic [XLEN-1:0]       data_q [DEPTH];
  logic [DEPTH-1:0]      kill_q;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full, empty, push_ok, pop_ok, push_kill;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push_i && !full;
  assign pop_ok  = pop_i && !empty;

  // The queued result is older than a same-cycle pipeline write to its register.
  assign push_kill = (push_addr_i == '0) || (kill_en_i && (kill_addr_i == push_addr_i));

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_ok && (wr_ptr_q == PW'(i))) begin
          kill_q[i] <= push_kill;
        end else if (kill_en_i && (kill_addr_i == addr_q[i])) begin
          kill_q[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign ready_o      = !full;
  assign head_valid_o = !empty;
  assign head_kill_o  = kill_q[rd_ptr_q];
  assign head_addr_o  = addr_q[rd_ptr_q];
  assign head_data_o  = data_q[rd_ptr_q];
  assign count_o      = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, buffered
// long-latency results fill idle cycles. Starvation monitor under WB_ARB_STARVE_EN.
module wb_port_arbiter
  import rv_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic              clk,
  input logic              rst_n,
  wb_port_arbiter_if.slave bus
);

  wb_req_t               pipe_req, wr_req;
  logic                  pipe_live, head_valid, head_kill, head_live, pop;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [XLEN-1:0]       head_data;
  logic                  lu_ready;
  logic [$clog2(DEPTH+1)-1:0] count;

  assign pipe_req.en   = bus.i_register_file_wr_en_W;
  assign pipe_req.addr = bus.i_register_file_wr_addr_W;
  assign pipe_req.data = bus.i_result_W;
  assign pipe_live     = wb_live(pipe_req);

  wb_lu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (bus.i_lu_valid),
    .push_addr_i (bus.i_lu_addr),
    .push_data_i (bus.i_lu_data),
    .pop_i       (pop),
    .kill_en_i   (pipe_live),
    .kill_addr_i (pipe_req.addr),
    .ready_o     (lu_ready),
    .head_valid_o(head_valid),
    .head_kill_o (head_kill),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .count_o     (count)
  );

  assign head_live = head_valid && !head_kill;
  // Killed heads drain without the port, so they pop even under pipeline traffic.
  assign pop       = head_valid && (head_kill || !pipe_live);

  always_comb begin
    wr_req = '0;
    if (pipe_live) begin
      wr_req = pipe_req;
    end else if (head_live) begin
      wr_req.en   = 1'b1;
      wr_req.addr = head_addr;
      wr_req.data = head_data;
    end
  end

  assign bus.o_rf_wr_en   = wr_req.en;
  assign bus.o_rf_wr_addr = wr_req.addr;
  assign bus.o_rf_wr_data = wr_req.data;
  assign bus.o_lu_ready   = lu_ready;
  assign bus.o_count      = count;

`ifdef WB_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;

  // Counts only cycles where a live head loses the port; a matching pipeline
  // write kills the head, which ends its wait as surely as writing it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!head_live || pop) begin
      starve_cnt_d = '0;
    end else if (pipe_req.addr == head_addr) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != SW'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign bus.o_starve = (starve_cnt_q >= SW'(STARVE_LIMIT));
`else
  assign bus.o_starve = 1'b0;
`endif

endmodule
